// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared constants and types for packed-BCD to binary conversion
package bcd_pkg;

  localparam int BCD_W   = 4;
  localparam int BCD_MAX = 9;
  localparam int NDIG    = 8;
  localparam int BW      = 24;
  localparam int AW      = 27;

  typedef logic [BCD_W-1:0] bcd_digit_t;
  typedef logic [AW-1:0]    acc_t;

  localparam acc_t BIN_MAX = acc_t'((64'd1 << BW) - 64'd1);

endpackage

// File: rtl/bcd_mac10.sv
// rtl/bcd_mac10.sv - combinational acc*10+d Horner step with non-BCD digit flag
module bcd_mac10
  import bcd_pkg::*;
(
  input  acc_t       acc,
  input  bcd_digit_t d,
  output acc_t       nxt,
  output logic       bad
);

  // acc*10 as (acc*8)+(acc*2); AW is wide enough that no wrap can occur
  assign nxt = (acc << 3) + (acc << 1) + acc_t'(d);
  assign bad = (d > bcd_digit_t'(BCD_MAX));

endmodule

// File: rtl/dec8_to_bin24.sv
// rtl/dec8_to_bin24.sv - sequential 8-digit packed BCD to 24-bit binary converter,
// one digit per clock, MS digit first, with overflow saturation and bad-digit flag
module dec8_to_bin24
  import bcd_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  st,
  input  logic [NDIG*BCD_W-1:0] DEC,
  output logic [BW-1:0]         BIN,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf,
  output logic                  err_dig
);

  logic [NDIG*BCD_W-1:0] shreg;
  acc_t                  acc;
  logic [3:0]            ptr;
  logic                  bad;

  bcd_digit_t digit;
  acc_t       nxt;
  logic       digit_bad;
  logic       err_fin;
  logic       ovf_fin;

  assign digit = shreg[NDIG*BCD_W-1 -: BCD_W];

  bcd_mac10 u_mac (
    .acc (acc),
    .d   (digit),
    .nxt (nxt),
    .bad (digit_bad)
  );

  // a bad digit masks overflow: the result is meaningless, so it is reported as error only
  assign err_fin = bad | digit_bad;
  assign ovf_fin = !err_fin && (nxt > BIN_MAX);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shreg   <= '0;
      acc     <= '0;
      ptr     <= '0;
      bad     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      BIN     <= '0;
      ovf     <= 1'b0;
      err_dig <= 1'b0;
    end else begin
      done <= 1'b0;
      if (st) begin
        shreg <= DEC;
        acc   <= '0;
        ptr   <= 4'(NDIG);
        busy  <= 1'b1;
        bad   <= 1'b0;
      end else if (busy) begin
        acc   <= nxt;
        shreg <= shreg << BCD_W;
        ptr   <= ptr - 4'd1;
        bad   <= err_fin;
        if (ptr == 4'd1) begin
          busy    <= 1'b0;
          done    <= 1'b1;
          err_dig <= err_fin;
          ovf     <= ovf_fin;
          if (err_fin)
            BIN <= '0;
          else if (ovf_fin)
            BIN <= {BW{1'b1}};
          else
            BIN <= nxt[BW-1:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_dec8_to_bin24.sv
// tb/tb_dec8_to_bin24.sv - scoreboard bench for dec8_to_bin24
module tb_dec8_to_bin24;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        st;
  logic [31:0] DEC;
  logic [23:0] BIN;
  logic        busy, done, ovf, err_dig;

  typedef struct {
    logic [23:0] bin;
    logic        ovf;
    logic        err;
    int          done_cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  logic prev_done = 1'b0;

  dec8_to_bin24 dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .st      (st),
    .DEC     (DEC),
    .BIN     (BIN),
    .busy    (busy),
    .done    (done),
    .ovf     (ovf),
    .err_dig (err_dig)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // monitor: pops one expectation per done pulse
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      chk("done_single_cycle", 32'(prev_done), 32'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("latency", 32'(cyc), 32'(e.done_cyc));
        chk("BIN", 32'(BIN), 32'(e.bin));
        chk("ovf", 32'(ovf), 32'(e.ovf));
        chk("err_dig", 32'(err_dig), 32'(e.err));
        chk("busy_at_done", 32'(busy), 32'd0);
      end
    end
    prev_done = done;
  end

  // called just after an edge; st is sampled on the following edge
  task automatic start(input logic [31:0] dec, input logic [23:0] bin,
                       input logic o, input logic e, input bit restart);
    exp_t x;
    if (restart && exp_q.size() > 0) void'(exp_q.pop_back());
    x.bin = bin; x.ovf = o; x.err = e; x.done_cyc = cyc + 1 + 8;
    exp_q.push_back(x);
    st  = 1'b1;
    DEC = dec;
    @(posedge clk); #1;
    st  = 1'b0;
    DEC = $urandom;
  endtask

  task automatic wait_edges(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((exp_q.size() != 0 || busy) && t < 60) begin
      @(posedge clk); #1; t++;
    end
    if (t >= 60) chk("idle_timeout", 32'd1, 32'd0);
    wait_edges(2);
  endtask

  initial begin
    rst_n = 1'b0; st = 1'b0; DEC = '0;
    wait_edges(2);
    chk("rst_BIN", 32'(BIN), 32'd0);
    chk("rst_flags", {28'd0, busy, done, ovf, err_dig}, 32'd0);
    rst_n = 1'b1;
    wait_edges(1);

    start(32'h12345678, 24'hBC614E, 1'b0, 1'b0, 1'b0); wait_idle();
    start(32'h16777215, 24'hFFFFFF, 1'b0, 1'b0, 1'b0); wait_idle();
    start(32'h16777216, 24'hFFFFFF, 1'b1, 1'b0, 1'b0); wait_idle();
    start(32'h99999999, 24'hFFFFFF, 1'b1, 1'b0, 1'b0); wait_idle();
    start(32'h00000000, 24'h000000, 1'b0, 1'b0, 1'b0); wait_idle();
    start(32'h0000001A, 24'h000000, 1'b0, 1'b1, 1'b0); wait_idle();
    start(32'h00000042, 24'h00002A, 1'b0, 1'b0, 1'b0); wait_idle();
    start(32'hF0000000, 24'h000000, 1'b0, 1'b1, 1'b0); wait_idle();

    // restart mid-conversion at edge k+4
    start(32'h00000099, 24'h000063, 1'b0, 1'b0, 1'b0);
    wait_edges(3);
    start(32'h00000007, 24'h000007, 1'b0, 1'b0, 1'b1); wait_idle();

    // restart coinciding with the final edge k+8
    start(32'h00000099, 24'h000063, 1'b0, 1'b0, 1'b0);
    wait_edges(7);
    start(32'h00000123, 24'h00007B, 1'b0, 1'b0, 1'b1); wait_idle();

    // reset aborts a conversion at cycle 3
    start(32'h00001234, 24'h0004D2, 1'b0, 1'b0, 1'b0);
    wait_edges(2);
    void'(exp_q.pop_back());
    rst_n = 1'b0;
    wait_edges(1);
    chk("abort_BIN", 32'(BIN), 32'd0);
    chk("abort_flags", {28'd0, busy, done, ovf, err_dig}, 32'd0);
    rst_n = 1'b1;
    wait_edges(12);
    chk("abort_no_done", 32'(busy), 32'd0);
    start(32'h00000500, 24'h0001F4, 1'b0, 1'b0, 1'b0); wait_idle();

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
